// File: rtl/arfs_flow_table_ctrl.sv
`timescale 1ns/1ps
// arfs_flow_table_ctrl: owns the single-port aRFS flow-table RAM.
// It shares the RAM between line-rate lookups and insert/update/delete requests.
// It also sweeps the table to zero after reset.
// Ports:
//   axis_aclk / axis_areset : clock and asynchronous active-high reset
//   lkp_*                   : lookup request (valid/ready, idx, key)
//   rsp_*                   : lookup response, two cycles after acceptance
//   upd_*                   : update request (valid/ready, op, idx, key, qid),
//                             with upd_done/upd_status completion
//   tbl_*                   : RAM port, entry {valid,key,qid}, read latency 1
module arfs_flow_table_ctrl #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned IDX_W      = $clog2(DEPTH),
  parameter int unsigned KEY_W      = 96,
  parameter int unsigned QID_W      = 11,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                     axis_aclk,
  input  logic                     axis_areset,
  input  logic                     lkp_valid,
  output logic                     lkp_ready,
  input  logic [IDX_W-1:0]         lkp_idx,
  input  logic [KEY_W-1:0]         lkp_key,
  output logic                     rsp_valid,
  output logic                     rsp_hit,
  output logic [QID_W-1:0]         rsp_qid,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic                     upd_op,
  input  logic [IDX_W-1:0]         upd_idx,
  input  logic [KEY_W-1:0]         upd_key,
  input  logic [QID_W-1:0]         upd_qid,
  output logic                     upd_done,
  output logic [2:0]               upd_status,
  output logic                     tbl_en,
  output logic                     tbl_we,
  output logic [IDX_W-1:0]         tbl_addr,
  output logic [KEY_W+QID_W:0]     tbl_wdata,
  input  logic [KEY_W+QID_W:0]     tbl_rdata
);

  localparam int unsigned ENT_W = 1 + KEY_W + QID_W;
  localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CMP, S_WR, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   init_cnt_q;
  logic [SC_W-1:0]    starve_q, starve_d;
  logic [2:0]         status_q, status_d;
  logic               cap_op_q;
  logic [IDX_W-1:0]   cap_idx_q;
  logic [KEY_W-1:0]   cap_key_q;
  logic [QID_W-1:0]   cap_qid_q;
  logic               lkp_p1_q;
  logic [KEY_W-1:0]   lkp_key_p1_q;
  logic               upd_grant, lkp_fire, upd_fire, upd_wants;

  // Entry fields of the word read back last cycle
  logic               e_valid;
  logic [KEY_W-1:0]   e_key;
  logic [QID_W-1:0]   e_qid;
  logic               upd_match, lkp_match;

  assign e_valid   = tbl_rdata[ENT_W-1];
  assign e_key     = tbl_rdata[QID_W +: KEY_W];
  assign e_qid     = tbl_rdata[QID_W-1:0];
  assign upd_match = e_valid && (e_key == cap_key_q);
  assign lkp_match = e_valid && (e_key == lkp_key_p1_q);
  assign upd_wants = (state_q == S_RD) || (state_q == S_WR);

  // Slot arbitration, RAM port mux and update FSM next state.
  // Port outputs are forced low while reset is held.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    status_d  = status_q;
    upd_grant = 1'b0;
    lkp_fire  = 1'b0;
    upd_fire  = 1'b0;
    lkp_ready = 1'b0;
    upd_ready = 1'b0;
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = '0;
    if (!axis_areset) begin
      if (state_q == S_INIT) begin
        tbl_en   = 1'b1;
        tbl_we   = 1'b1;
        tbl_addr = init_cnt_q;
        if (init_cnt_q == IDX_W'(DEPTH - 1)) state_d = S_IDLE;
      end else begin
        // A waiting update takes the slot when no lookup competes or lookups have had their quota
        upd_grant = upd_wants && (!lkp_valid || (starve_q == SC_W'(STARVE_MAX)));
        lkp_ready = !upd_grant;
        upd_ready = (state_q == S_IDLE);
        lkp_fire  = lkp_valid && lkp_ready;
        upd_fire  = upd_valid && upd_ready;
        if (upd_grant) begin
          starve_d = '0;
          tbl_en   = 1'b1;
          tbl_we   = (state_q == S_WR);
          tbl_addr = cap_idx_q;
          if ((state_q == S_WR) && !cap_op_q) tbl_wdata = {1'b1, cap_key_q, cap_qid_q};
        end else if (lkp_fire) begin
          tbl_en   = 1'b1;
          tbl_addr = lkp_idx;
          if (upd_wants) starve_d = starve_q + SC_W'(1);
        end
        case (state_q)
          S_IDLE: if (upd_fire) state_d = S_RD;
          S_RD:   if (upd_grant) state_d = S_CMP;
          S_CMP: begin
            if (!cap_op_q) begin
              status_d = !e_valid ? 3'b000 : (upd_match ? 3'b001 : 3'b010);
              state_d  = S_WR;
            end else if (upd_match) begin
              status_d = 3'b011;
              state_d  = S_WR;
            end else begin
              status_d = 3'b100;
              state_d  = S_DONE;
            end
          end
          S_WR:   if (upd_grant) state_d = S_DONE;
          S_DONE: state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // State, capture, lookup pipeline and registered outputs
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      starve_q     <= '0;
      status_q     <= '0;
      cap_op_q     <= 1'b0;
      cap_idx_q    <= '0;
      cap_key_q    <= '0;
      cap_qid_q    <= '0;
      lkp_p1_q     <= 1'b0;
      lkp_key_p1_q <= '0;
      rsp_valid    <= 1'b0;
      rsp_hit      <= 1'b0;
      rsp_qid      <= '0;
      upd_done     <= 1'b0;
      upd_status   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      status_q <= status_d;
      if (state_q == S_INIT) init_cnt_q <= init_cnt_q + IDX_W'(1);
      if (upd_fire) begin
        cap_op_q  <= upd_op;
        cap_idx_q <= upd_idx;
        cap_key_q <= upd_key;
        cap_qid_q <= upd_qid;
      end
      lkp_p1_q <= lkp_fire;
      if (lkp_fire) lkp_key_p1_q <= lkp_key;
      rsp_valid  <= lkp_p1_q;
      rsp_hit    <= lkp_p1_q && lkp_match;
      rsp_qid    <= (lkp_p1_q && lkp_match) ? e_qid : '0;
      upd_done   <= (state_d == S_DONE);
      upd_status <= (state_d == S_DONE) ? status_d : 3'b000;
    end
  end

endmodule

// File: tb/tb_arfs_flow_table_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for arfs_flow_table_ctrl with a behavioural flow-table model
// and a simple 1-cycle-latency RAM attached to the tbl_* port.
module tb_arfs_flow_table_ctrl;

  localparam int unsigned DEPTH      = 256;
  localparam int unsigned IDX_W      = 8;
  localparam int unsigned KEY_W      = 96;
  localparam int unsigned QID_W      = 11;
  localparam int unsigned ENT_W      = 1 + KEY_W + QID_W;
  localparam int unsigned STARVE_MAX = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               lkp_valid, lkp_ready, rsp_valid, rsp_hit;
  logic [IDX_W-1:0]   lkp_idx;
  logic [KEY_W-1:0]   lkp_key;
  logic [QID_W-1:0]   rsp_qid;
  logic               upd_valid, upd_ready, upd_op, upd_done;
  logic [IDX_W-1:0]   upd_idx;
  logic [KEY_W-1:0]   upd_key;
  logic [QID_W-1:0]   upd_qid;
  logic [2:0]         upd_status;
  logic               tbl_en, tbl_we;
  logic [IDX_W-1:0]   tbl_addr;
  logic [ENT_W-1:0]   tbl_wdata, tbl_rdata;

  arfs_flow_table_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .KEY_W(KEY_W), .QID_W(QID_W),
                         .STARVE_MAX(STARVE_MAX)) dut (
    .axis_aclk(clk), .axis_areset(rst),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_idx(lkp_idx), .lkp_key(lkp_key),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_qid(rsp_qid),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op), .upd_idx(upd_idx),
    .upd_key(upd_key), .upd_qid(upd_qid), .upd_done(upd_done), .upd_status(upd_status),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .tbl_rdata(tbl_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Table RAM, preloaded with valid-looking garbage so a missing sweep is visible
  logic [ENT_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata     <= mem[tbl_addr];
    end
  end

  // Behavioural model: per-index entry
  bit               m_valid [DEPTH];
  logic [KEY_W-1:0] m_key   [DEPTH];
  logic [QID_W-1:0] m_qid   [DEPTH];

  typedef struct { bit hit; logic [QID_W-1:0] qid; int cyc; } lexp_t;
  lexp_t      lkp_q [$];
  logic [2:0] upd_q [$];

  int errors = 0;
  int checks = 0;
  bit upd_busy = 0;
  logic [IDX_W-1:0] busy_idx = '0;
  int hs_cyc = 32'h7fffffff;
  logic [KEY_W-1:0] keys [3];

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0; m_key[i] = '0; m_qid[i] = '0;
    end
  endfunction

  function automatic lexp_t lkp_model(input logic [IDX_W-1:0] idx, input logic [KEY_W-1:0] key);
    lexp_t r;
    r.hit = m_valid[idx] && (m_key[idx] == key);
    r.qid = r.hit ? m_qid[idx] : '0;
    r.cyc = cyc;
    return r;
  endfunction

  function automatic logic [2:0] upd_model(input bit op, input logic [IDX_W-1:0] idx,
                                           input logic [KEY_W-1:0] key, input logic [QID_W-1:0] qid);
    bit match = m_valid[idx] && (m_key[idx] == key);
    logic [2:0] s;
    if (!op) begin
      s = !m_valid[idx] ? 3'd0 : (match ? 3'd1 : 3'd2);
      m_valid[idx] = 1'b1; m_key[idx] = key; m_qid[idx] = qid;
    end else if (match) begin
      s = 3'd3;
      m_valid[idx] = 1'b0;
    end else begin
      s = 3'd4;
    end
    return s;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a response or completion
  always @(negedge clk) begin
    lexp_t e;
    if (rsp_valid) begin
      if (lkp_q.size() == 0) check_eq("rsp_unexpected", rsp_valid, 0);
      else begin
        e = lkp_q.pop_front();
        check_eq("rsp_hit", rsp_hit, e.hit);
        check_eq("rsp_qid", rsp_qid, e.qid);
        check_eq("rsp_latency", cyc - e.cyc, 2);
      end
    end
    if (upd_done) begin
      if (upd_q.size() == 0) check_eq("upd_done_unexpected", upd_done, 0);
      else check_eq("upd_status", upd_status, upd_q.pop_front());
      upd_busy = 0;
    end
  end

  task automatic do_upd(input bit op, input logic [IDX_W-1:0] idx,
                        input logic [KEY_W-1:0] key, input logic [QID_W-1:0] qid);
    bit acc = 0;
    @(posedge clk); #1;
    upd_valid = 1; upd_op = op; upd_idx = idx; upd_key = key; upd_qid = qid;
    for (int t = 0; t < 2000 && !acc; t++) begin
      @(negedge clk);
      if (upd_ready) begin acc = 1; upd_busy = 1; busy_idx = idx; hs_cyc = cyc; end
      @(posedge clk); #1;
    end
    upd_valid = 0;
    if (!acc) check_eq("upd_accept_timeout", upd_ready, 1);
    else upd_q.push_back(upd_model(op, idx, key, qid));
  endtask

  task automatic wait_upd_idle();
    for (int t = 0; t < 2000 && upd_busy; t++) @(negedge clk);
    if (upd_busy) begin
      check_eq("upd_done_timeout", upd_done, 1);
      upd_busy = 0; upd_q.delete();
    end
  endtask

  task automatic do_lkp(input logic [IDX_W-1:0] idx, input logic [KEY_W-1:0] key);
    bit acc = 0;
    @(posedge clk); #1;
    lkp_valid = 1; lkp_idx = idx; lkp_key = key;
    for (int t = 0; t < 2000 && !acc; t++) begin
      @(negedge clk);
      if (lkp_ready) begin acc = 1; lkp_q.push_back(lkp_model(idx, key)); end
      @(posedge clk); #1;
    end
    lkp_valid = 0;
    if (!acc) check_eq("lkp_accept_timeout", lkp_ready, 1);
  endtask

  task automatic drain_lkp();
    for (int t = 0; t < 100 && lkp_q.size() != 0; t++) @(negedge clk);
    if (lkp_q.size() != 0) begin
      check_eq("rsp_timeout", rsp_valid, 1);
      lkp_q.delete();
    end
  endtask

  // Called right after reset release: one RAM write per cycle, addr 0..DEPTH-1, ready held low
  task automatic check_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check_eq($sformatf("sweep_%0d", i),
               {tbl_en, tbl_we, lkp_ready, upd_ready, tbl_addr, tbl_wdata},
               {1'b1, 1'b1, 1'b0, 1'b0, IDX_W'(i), {ENT_W{1'b0}}});
    end
    @(negedge clk);
    check_eq("ready_after_sweep", {lkp_ready, upd_ready}, 2'b11);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    lkp_valid = 0; lkp_idx = '0; lkp_key = '0;
    upd_valid = 0; upd_op = 0; upd_idx = '0; upd_key = '0; upd_qid = '0;
    keys[0] = {32'h0a000001, 32'h0a000002, 16'd1234, 16'd80};
    keys[1] = {32'hc0a80001, 32'hc0a80063, 16'd5555, 16'd443};
    keys[2] = {32'hac100005, 32'hac100006, 16'd999, 16'd53};
    for (int i = 0; i < DEPTH; i++) mem[i] = {1'b1, KEY_W'(i), {QID_W{1'b1}}};
    clear_model();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs",
             {lkp_ready, rsp_valid, rsp_hit, rsp_qid, upd_ready, upd_done, upd_status, tbl_en, tbl_we, tbl_addr},
             '0);
    check_eq("reset_wdata", tbl_wdata, '0);
    @(posedge clk); #1 rst = 0;
    check_sweep();

    // Swept entry with a key matching the old garbage must miss
    do_lkp(9, KEY_W'(9));
    // Insert / update / evict / delete sequence on index 5
    do_upd(0, 5, keys[0], 11'h0fa); wait_upd_idle();
    do_lkp(5, keys[0]); drain_lkp();
    do_upd(0, 5, keys[0], 11'h0fb); wait_upd_idle();
    do_lkp(5, keys[0]); drain_lkp();
    do_upd(0, 5, keys[1], 11'h010); wait_upd_idle();
    do_lkp(5, keys[0]);
    do_lkp(5, keys[1]); drain_lkp();
    do_upd(1, 5, keys[0], 11'h000); wait_upd_idle();
    do_upd(1, 5, keys[1], 11'h000); wait_upd_idle();
    do_lkp(5, keys[1]); drain_lkp();

    // Starvation: lookups back-to-back while an update waits for a slot
    do_upd(0, 200, keys[2], 11'h123); wait_upd_idle();
    hs_cyc = 32'h7fffffff;
    fork
      begin
        int cnt;
        bit meas;
        cnt = 0; meas = 1;
        @(posedge clk); #1;
        lkp_valid = 1; lkp_idx = 200; lkp_key = keys[2];
        for (int t = 0; t < 40; t++) begin
          @(negedge clk);
          if (lkp_ready) lkp_q.push_back(lkp_model(lkp_idx, lkp_key));
          if (meas && cyc > hs_cyc) begin
            if (lkp_ready) cnt++;
            else begin
              meas = 0;
              check_eq("starve_grants", cnt, STARVE_MAX);
              check_eq("starve_slot", {tbl_en, tbl_we, tbl_addr}, {1'b1, 1'b0, IDX_W'(7)});
            end
          end
          @(posedge clk); #1;
        end
        lkp_valid = 0;
        if (meas) check_eq("starve_grants", cnt, STARVE_MAX);
      end
      begin
        repeat (3) @(posedge clk);
        do_upd(0, 7, keys[0], 11'h055);
      end
    join
    wait_upd_idle(); drain_lkp();
    do_lkp(7, keys[0]); drain_lkp();

    // Randomized concurrent traffic on a small index range
    fork
      begin
        bit hold;
        hold = 0;
        for (int t = 0; t < 900; t++) begin
          @(posedge clk); #1;
          if (!hold) begin
            lkp_valid = ($urandom_range(0, 9) < 7);
            lkp_idx   = IDX_W'($urandom_range(0, 15));
            if (upd_busy && lkp_idx == busy_idx) lkp_idx = lkp_idx ^ IDX_W'(1);
            lkp_key   = keys[$urandom_range(0, 2)];
          end
          @(negedge clk);
          if (lkp_valid && lkp_ready) begin
            lkp_q.push_back(lkp_model(lkp_idx, lkp_key));
            hold = 0;
          end else hold = lkp_valid;
        end
        @(posedge clk); #1 lkp_valid = 0;
      end
      begin
        for (int u = 0; u < 40; u++) begin
          do_upd($urandom_range(0, 3) == 0, IDX_W'($urandom_range(0, 15)),
                 keys[$urandom_range(0, 2)], QID_W'($urandom));
          wait_upd_idle();
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
    join
    wait_upd_idle(); drain_lkp();

    // Reset while the update sits in CMP
    lkp_valid = 0;
    do_upd(0, 3, keys[0], 11'h0aa);
    @(negedge clk);
    check_eq("rd_slot", {tbl_en, tbl_we, tbl_addr}, {1'b1, 1'b0, IDX_W'(3)});
    @(posedge clk); #1;
    lkp_valid = 1; lkp_idx = 3; lkp_key = keys[0];
    @(negedge clk);
    rst = 1;
    upd_q.delete(); lkp_q.delete(); upd_busy = 0;
    clear_model();
    #1;
    check_eq("reset_mid_outputs", {lkp_ready, upd_ready, tbl_en, rsp_valid, upd_done}, '0);
    lkp_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("abort_quiet", {rsp_valid, upd_done}, 2'b00);
    end
    @(posedge clk); #1 rst = 0;
    check_sweep();
    do_lkp(3, keys[0]); drain_lkp();
    do_upd(0, 3, keys[0], 11'h0ab); wait_upd_idle();
    do_lkp(3, keys[0]); drain_lkp();

    repeat (5) @(negedge clk);
    check_eq("lkp_q_empty", lkp_q.size(), 0);
    check_eq("upd_q_empty", upd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
